// File: rtl/enc_binder_pack_tm.sv
// -----------------------------------------------------------------------------
// enc_binder_pack_tm
// Time-multiplexed binder pack. Rotates FEATURES level hypervectors by a
// per-feature shift using LANES shared rotators, one group of LANES features
// per cycle, under a start/busy/done handshake.
//
// Ports:
//   clk            rising-edge clock
//   nrst           asynchronous active-low reset
//   start_encoding request a binding pass (sampled only while idle)
//   mode           00 rotate-left, 01 rotate-right, 1x bypass (latched at start)
//   level_hv       input hypervectors, held stable while busy
//   shifted_hv     bound hypervectors (registered)
//   shifted_valid  shifted_hv holds a complete pass result
//   busy           a pass is in progress (bind or done state)
//   done           one-cycle pulse when the pass completes
//
// enc_binder_pack_tm_chk holds the structural assertions for the pack.
// -----------------------------------------------------------------------------

module enc_binder_pack_tm_chk #(
  parameter int FEATURES = 16,
  parameter int LANES    = 4,
  parameter int GW       = 3
) (
  input logic             clk,
  input logic             nrst,
  input logic             bind_active,
  input logic [GW-1:0]    grp,
  input logic [LANES-1:0] lane_we,
  input logic             done,
  input logic             busy
);
  localparam int G = (FEATURES + LANES - 1) / LANES;

  // the group counter never runs past the last group while binding
  a_grp_range: assert property (@(posedge clk) disable iff (!nrst)
    bind_active |-> (int'(grp) < G));

  // done is a single-cycle pulse and only occurs while busy
  a_done_pulse: assert property (@(posedge clk) disable iff (!nrst)
    done |=> !done);
  a_done_busy: assert property (@(posedge clk) disable iff (!nrst)
    done |-> busy);

  // a lane only writes when its feature index exists
  for (genvar l = 0; l < LANES; l++) begin : g_lane_chk
    a_lane_exists: assert property (@(posedge clk) disable iff (!nrst)
      lane_we[l] |-> ((int'(grp) * LANES + l) < FEATURES));
  end
endmodule

module enc_binder_pack_tm #(
  parameter int HV_DIM     = 1024,
  parameter int FEATURES   = 16,
  parameter int LANES      = 4,
  parameter int SHIFT_BASE = 62,
  parameter int SHIFT_STEP = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_encoding,
  input  logic [1:0]        mode,
  input  logic [HV_DIM-1:0] level_hv   [0:FEATURES-1],
  output logic [HV_DIM-1:0] shifted_hv [0:FEATURES-1],
  output logic              shifted_valid,
  output logic              busy,
  output logic              done
);
  localparam int G  = (FEATURES + LANES - 1) / LANES;
  // grp counts up to G (it increments on the final group too)
  localparam int GW = $clog2(G + 1);
  localparam int SW = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BIND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        mode_r;
  logic [GW-1:0]     grp_r;
  logic              valid_r;
  logic              busy_r;
  logic              done_r;
  logic [HV_DIM-1:0] hv_r        [0:FEATURES-1];
  logic [SW-1:0]     shift_tab_s [0:FEATURES-1];
  logic [HV_DIM-1:0] lane_in_s   [0:LANES-1];
  logic [HV_DIM-1:0] lane_out_s  [0:LANES-1];
  logic [SW-1:0]     lane_sh_s   [0:LANES-1];
  logic [LANES-1:0]  lane_vld_s;
  logic [LANES-1:0]  lane_we_s;
  logic              bind_s;

  assign bind_s    = (state_r == ST_BIND);
  assign lane_we_s = {LANES{bind_s}} & lane_vld_s;

  assign shifted_hv    = hv_r;
  assign shifted_valid = valid_r;
  assign busy          = busy_r;
  assign done          = done_r;

  // Per-feature shift amounts are pure elaboration-time constants.
  for (genvar f = 0; f < FEATURES; f++) begin : g_shift_tab
    assign shift_tab_s[f] = SW'((SHIFT_BASE + f * SHIFT_STEP) % HV_DIM);
  end

  // Route the current group's features and shifts onto the lanes. Exactly one
  // group matches grp_r, so the OR-accumulation acts as a one-hot mux; lanes
  // past the last feature stay zero and are flagged invalid.
  always_comb begin : lane_sel
    logic hit_v;
    int   idx_v;
    hit_v = 1'b0;
    idx_v = 0;
    for (int l = 0; l < LANES; l++) begin
      lane_in_s[l]  = '0;
      lane_sh_s[l]  = '0;
      lane_vld_s[l] = 1'b0;
      for (int k = 0; k < G; k++) begin
        hit_v = (grp_r == GW'(k)) && ((k * LANES + l) < FEATURES);
        idx_v = ((k * LANES + l) < FEATURES) ? (k * LANES + l) : (FEATURES - 1);
        lane_in_s[l]  = lane_in_s[l] | ({HV_DIM{hit_v}} & level_hv[idx_v]);
        lane_sh_s[l]  = lane_sh_s[l] | ({SW{hit_v}} & shift_tab_s[idx_v]);
        lane_vld_s[l] = lane_vld_s[l] | hit_v;
      end
    end
  end

  // Shared rotators: two-shift barrel rotate in the latched direction.
  always_comb begin : lane_rot
    logic [SW:0] inv_v;
    inv_v = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_out_s[l] = '0;
      // complementary shift; equals HV_DIM for s=0, which yields zero fill
      inv_v = (SW + 1)'(HV_DIM) - {1'b0, lane_sh_s[l]};
      case (mode_r)
        2'b00:   lane_out_s[l] = (lane_in_s[l] << lane_sh_s[l]) | (lane_in_s[l] >> inv_v);
        2'b01:   lane_out_s[l] = (lane_in_s[l] >> lane_sh_s[l]) | (lane_in_s[l] << inv_v);
        default: lane_out_s[l] = lane_in_s[l];
      endcase
    end
  end

  // Pass sequencing: idle -> one bind cycle per group -> one done cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= ST_IDLE;
      mode_r  <= 2'b00;
      grp_r   <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_encoding) begin
            mode_r  <= mode;
            valid_r <= 1'b0;
            grp_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_BIND;
          end
        end
        ST_BIND: begin
          grp_r <= grp_r + GW'(1);
          if (grp_r == GW'(G - 1)) begin
            done_r  <= 1'b1;
            valid_r <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Result registers: a feature is written only in the bind cycle of its group.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int f = 0; f < FEATURES; f++) begin
        hv_r[f] <= '0;
      end
    end else begin
      for (int f = 0; f < FEATURES; f++) begin
        if (bind_s && (grp_r == GW'(f / LANES))) begin
          hv_r[f] <= lane_out_s[f % LANES];
        end
      end
    end
  end

  enc_binder_pack_tm_chk #(
    .FEATURES (FEATURES),
    .LANES    (LANES),
    .GW       (GW)
  ) u_chk (
    .clk         (clk),
    .nrst        (nrst),
    .bind_active (bind_s),
    .grp         (grp_r),
    .lane_we     (lane_we_s),
    .done        (done_r),
    .busy        (busy_r)
  );
endmodule

// File: tb/tb_enc_binder_pack_tm.sv
// -----------------------------------------------------------------------------
// tb_enc_binder_pack_tm
// Self-checking bench for enc_binder_pack_tm. Three instances: the default
// configuration (16 features, 4 lanes), an uneven one (6 features, 4 lanes)
// and a single-group one (4 features, 4 lanes, 64-bit vectors). Expected
// results come from a bit-by-bit rotation model.
// -----------------------------------------------------------------------------
module tb_enc_binder_pack_tm;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst;
  int   vecs = 0;
  int   errs = 0;

  // default instance
  logic         st0;
  logic [1:0]   md0;
  logic [1023:0] lv0 [0:15];
  logic [1023:0] sh0 [0:15];
  logic         v0, b0, d0;

  // uneven instance
  logic         st1;
  logic [1:0]   md1;
  logic [1023:0] lv1 [0:5];
  logic [1023:0] sh1 [0:5];
  logic         v1, b1, d1;

  // single-group instance
  logic         st2;
  logic [1:0]   md2;
  logic [63:0]  lv2 [0:3];
  logic [63:0]  sh2 [0:3];
  logic         v2, b2, d2;

  enc_binder_pack_tm u_dut0 (
    .clk(clk), .nrst(nrst), .start_encoding(st0), .mode(md0), .level_hv(lv0),
    .shifted_hv(sh0), .shifted_valid(v0), .busy(b0), .done(d0));

  enc_binder_pack_tm #(.HV_DIM(1024), .FEATURES(6), .LANES(4), .SHIFT_BASE(62), .SHIFT_STEP(1)) u_dut1 (
    .clk(clk), .nrst(nrst), .start_encoding(st1), .mode(md1), .level_hv(lv1),
    .shifted_hv(sh1), .shifted_valid(v1), .busy(b1), .done(d1));

  enc_binder_pack_tm #(.HV_DIM(64), .FEATURES(4), .LANES(4), .SHIFT_BASE(5), .SHIFT_STEP(3)) u_dut2 (
    .clk(clk), .nrst(nrst), .start_encoding(st2), .mode(md2), .level_hv(lv2),
    .shifted_hv(sh2), .shifted_valid(v2), .busy(b2), .done(d2));

  // ---------------- reference model ----------------
  function automatic int ref_shift(input int base, input int step, input int i, input int dim);
    return (base + i * step) % dim;
  endfunction

  function automatic logic [1023:0] ref_bind(input logic [1023:0] x, input int dim,
                                             input int s, input logic [1:0] md);
    logic [1023:0] y;
    y = '0;
    for (int b = 0; b < dim; b++) begin
      if (md == 2'b00)      y[(b + s) % dim] = x[b];
      else if (md == 2'b01) y[b] = x[(b + s) % dim];
      else                  y[b] = x[b];
    end
    return y;
  endfunction

  function automatic logic [1023:0] rand_hv();
    logic [1023:0] r;
    for (int w = 0; w < 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // Start one pass on the default instance and watch it for 16 cycles.
  // dcyc = cycle index (0 = first cycle after the start-sampling edge) of the
  // first done pulse. With disturb set, start is re-pulsed and mode flipped
  // while the pass is binding.
  task automatic run0(input logic [1:0] md, input bit disturb,
                      output int dcyc, output int bcyc, output int npulse);
    dcyc = -1; bcyc = 0; npulse = 0;
    @(posedge clk); #1; md0 = md; st0 = 1'b1;
    @(posedge clk); #1; st0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (disturb && i == 1) begin st0 = 1'b1; md0 = ~md; end
      if (disturb && i == 2) st0 = 1'b0;
      if (d0 === 1'b1) begin npulse++; if (dcyc < 0) dcyc = i; end
      if (b0 === 1'b1) bcyc++;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vecs++; if ({v0, b0, d0} !== 3'b000) begin errs++; $display("FAIL reset_ctrl got=%b exp=000", {v0, b0, d0}); end
    for (int f = 0; f < 16; f++) begin
      vecs++; if (sh0[f] !== '0) begin errs++; $display("FAIL reset_hv f=%0d got_lo=%h exp=0", f, sh0[f][127:0]); end
    end
    vecs++; if ({v1, b1, d1, v2, b2, d2} !== 6'b0) begin errs++; $display("FAIL reset_other got=%b exp=000000", {v1, b1, d1, v2, b2, d2}); end
  endtask

  task automatic test_rotate(input logic [1:0] md);
    int dc, bc, np;
    logic [1023:0] e;
    for (int f = 0; f < 16; f++) lv0[f] = '0;
    lv0[0][0] = 1'b1;
    lv0[3][1023] = 1'b1;
    run0(md, 1'b0, dc, bc, np);
    vecs++; if (dc != 4)  begin errs++; $display("FAIL rot_done_cycle md=%0d got=%0d exp=4", md, dc); end
    vecs++; if (bc != 5)  begin errs++; $display("FAIL rot_busy_cycles md=%0d got=%0d exp=5", md, bc); end
    vecs++; if (np != 1)  begin errs++; $display("FAIL rot_done_pulses md=%0d got=%0d exp=1", md, np); end
    vecs++; if (v0 !== 1'b1) begin errs++; $display("FAIL rot_valid md=%0d got=%b exp=1", md, v0); end
    e = '0; e[(md == 2'b00) ? 62 : 962] = 1'b1;
    vecs++; if (sh0[0] !== e) begin errs++; $display("FAIL rot_f0 md=%0d got_ones=%0d got_bit=%b exp_bit=1", md, $countones(sh0[0]), sh0[0][(md == 2'b00) ? 62 : 962]); end
    e = '0; e[(md == 2'b00) ? 64 : 958] = 1'b1;
    vecs++; if (sh0[3] !== e) begin errs++; $display("FAIL rot_f3 md=%0d got_ones=%0d got_bit=%b exp_bit=1", md, $countones(sh0[3]), sh0[3][(md == 2'b00) ? 64 : 958]); end
    // random data through the same direction
    for (int f = 0; f < 16; f++) lv0[f] = rand_hv();
    run0(md, 1'b0, dc, bc, np);
    for (int f = 0; f < 16; f++) begin
      e = ref_bind(lv0[f], 1024, ref_shift(62, 1, f, 1024), md);
      vecs++; if (sh0[f] !== e) begin errs++; $display("FAIL rot_rand md=%0d f=%0d got_lo=%h exp_lo=%h", md, f, sh0[f][127:0], e[127:0]); end
    end
  endtask

  task automatic test_bypass();
    int dc, bc, np;
    for (int m = 2; m < 4; m++) begin
      for (int f = 0; f < 16; f++) lv0[f] = rand_hv();
      run0(2'(m), 1'b0, dc, bc, np);
      vecs++; if (np != 1) begin errs++; $display("FAIL byp_pulses md=%0d got=%0d exp=1", m, np); end
      for (int f = 0; f < 16; f++) begin
        vecs++; if (sh0[f] !== lv0[f]) begin errs++; $display("FAIL bypass md=%0d f=%0d got_lo=%h exp_lo=%h", m, f, sh0[f][127:0], lv0[f][127:0]); end
      end
    end
  endtask

  task automatic test_ignore_start();
    int dc, bc, np;
    logic [1023:0] e;
    for (int f = 0; f < 16; f++) lv0[f] = rand_hv();
    run0(2'b01, 1'b1, dc, bc, np);
    vecs++; if (np != 1) begin errs++; $display("FAIL ign_pulses got=%0d exp=1", np); end
    vecs++; if (bc != 5) begin errs++; $display("FAIL ign_busy got=%0d exp=5", bc); end
    vecs++; if (dc != 4) begin errs++; $display("FAIL ign_done_cycle got=%0d exp=4", dc); end
    for (int f = 0; f < 16; f++) begin
      e = ref_bind(lv0[f], 1024, ref_shift(62, 1, f, 1024), 2'b01);
      vecs++; if (sh0[f] !== e) begin errs++; $display("FAIL ign_result f=%0d got_lo=%h exp_lo=%h", f, sh0[f][127:0], e[127:0]); end
    end
  endtask

  task automatic test_uneven();
    logic [1023:0] ea [0:5];
    logic [1023:0] eb [0:5];
    int dc, bc, np;
    logic [1:0] mb;
    // first pass leaves known values behind
    for (int f = 0; f < 6; f++) begin
      lv1[f] = rand_hv();
      ea[f]  = ref_bind(lv1[f], 1024, ref_shift(62, 1, f, 1024), 2'b00);
    end
    @(posedge clk); #1; md1 = 2'b00; st1 = 1'b1;
    @(posedge clk); #1; st1 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    for (int f = 0; f < 6; f++) begin
      vecs++; if (sh1[f] !== ea[f]) begin errs++; $display("FAIL unev_a f=%0d got_lo=%h exp_lo=%h", f, sh1[f][127:0], ea[f][127:0]); end
    end
    // second pass, random rotate direction
    mb = 2'($urandom_range(1, 0));
    for (int f = 0; f < 6; f++) begin
      lv1[f] = rand_hv();
      eb[f]  = ref_bind(lv1[f], 1024, ref_shift(62, 1, f, 1024), mb);
    end
    dc = -1; bc = 0; np = 0;
    @(posedge clk); #1; md1 = mb; st1 = 1'b1;
    @(posedge clk); #1; st1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        vecs++; if (v1 !== 1'b0) begin errs++; $display("FAIL unev_mid_valid got=%b exp=0", v1); end
        for (int f = 0; f < 6; f++) begin
          vecs++;
          if (sh1[f] !== ((f < 4) ? eb[f] : ea[f])) begin
            errs++; $display("FAIL unev_mid f=%0d got_lo=%h exp_lo=%h", f, sh1[f][127:0], ((f < 4) ? eb[f][127:0] : ea[f][127:0]));
          end
        end
      end
      if (d1 === 1'b1) begin np++; if (dc < 0) dc = i; end
      if (b1 === 1'b1) bc++;
      @(posedge clk); #1;
    end
    vecs++; if (dc != 2) begin errs++; $display("FAIL unev_done_cycle got=%0d exp=2", dc); end
    vecs++; if (bc != 3) begin errs++; $display("FAIL unev_busy got=%0d exp=3", bc); end
    vecs++; if (np != 1) begin errs++; $display("FAIL unev_pulses got=%0d exp=1", np); end
    vecs++; if (v1 !== 1'b1) begin errs++; $display("FAIL unev_valid got=%b exp=1", v1); end
    for (int f = 0; f < 6; f++) begin
      vecs++; if (sh1[f] !== eb[f]) begin errs++; $display("FAIL unev_b f=%0d got_lo=%h exp_lo=%h", f, sh1[f][127:0], eb[f][127:0]); end
    end
  endtask

  task automatic test_single_group();
    int dc, bc, np;
    logic [1023:0] e;
    for (int p = 0; p < 3; p++) begin
      for (int f = 0; f < 4; f++) lv2[f] = {$urandom, $urandom};
      md2 = 2'(p);
      dc = -1; bc = 0; np = 0;
      @(posedge clk); #1; st2 = 1'b1;
      @(posedge clk); #1; st2 = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (d2 === 1'b1) begin np++; if (dc < 0) dc = i; end
        if (b2 === 1'b1) bc++;
        @(posedge clk); #1;
      end
      vecs++; if (dc != 1) begin errs++; $display("FAIL g1_done_cycle md=%0d got=%0d exp=1", p, dc); end
      vecs++; if (bc != 2) begin errs++; $display("FAIL g1_busy md=%0d got=%0d exp=2", p, bc); end
      for (int f = 0; f < 4; f++) begin
        e = ref_bind({960'b0, lv2[f]}, 64, ref_shift(5, 3, f, 64), md2);
        vecs++; if (sh2[f] !== e[63:0]) begin errs++; $display("FAIL g1_result md=%0d f=%0d got=%h exp=%h", p, f, sh2[f], e[63:0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int dc, bc, np;
    logic [1023:0] e;
    for (int f = 0; f < 16; f++) lv0[f] = rand_hv();
    @(posedge clk); #1; md0 = 2'b00; st0 = 1'b1;
    @(posedge clk); #1; st0 = 1'b0;
    @(posedge clk); #1;          // inside the second bind cycle
    #1; nrst = 1'b0; #1;
    vecs++; if ({v0, b0, d0} !== 3'b000) begin errs++; $display("FAIL rstmid_ctrl got=%b exp=000", {v0, b0, d0}); end
    for (int f = 0; f < 16; f++) begin
      vecs++; if (sh0[f] !== '0) begin errs++; $display("FAIL rstmid_hv f=%0d got_lo=%h exp=0", f, sh0[f][127:0]); end
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vecs++; if (d0 !== 1'b0) begin errs++; $display("FAIL rstmid_done i=%0d got=%b exp=0", i, d0); end
    end
    nrst = 1'b1;
    for (int f = 0; f < 16; f++) lv0[f] = rand_hv();
    run0(2'b01, 1'b0, dc, bc, np);
    vecs++; if (dc != 4) begin errs++; $display("FAIL rstmid_after_done got=%0d exp=4", dc); end
    vecs++; if (np != 1) begin errs++; $display("FAIL rstmid_after_pulses got=%0d exp=1", np); end
    for (int f = 0; f < 16; f++) begin
      e = ref_bind(lv0[f], 1024, ref_shift(62, 1, f, 1024), 2'b01);
      vecs++; if (sh0[f] !== e) begin errs++; $display("FAIL rstmid_after f=%0d got_lo=%h exp_lo=%h", f, sh0[f][127:0], e[127:0]); end
    end
  endtask

  initial begin
    nrst = 1'b0;
    st0 = 1'b0; md0 = 2'b00;
    st1 = 1'b0; md1 = 2'b00;
    st2 = 1'b0; md2 = 2'b00;
    for (int f = 0; f < 16; f++) lv0[f] = '0;
    for (int f = 0; f < 6; f++)  lv1[f] = '0;
    for (int f = 0; f < 4; f++)  lv2[f] = '0;
    repeat (3) @(posedge clk);
    #1; nrst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_rotate(2'b00);
    test_rotate(2'b01);
    test_bypass();
    test_ignore_start();
    test_uneven();
    test_single_group();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
